// File: rtl/vdc_pixelshift_if.sv
// rtl/vdc_pixelshift_if.sv - per-pixel stream between the RAM interface and the pixel serializer
//
// Ports (signals):
//   enable     pixel clock enable
//   frame      start-of-frame strobe (qualified by enable)
//   load       start of a new character cell
//   disp       cell lies inside the display window (sampled with load)
//   char_in    character row / bitmap byte, MSB leftmost
//   attr_in    attribute byte: [6] reverse, [5] underline, [4] blink, [3:0] foreground
//   line       current scanline within the character row
//   cursor_hit cell is the cursor position (sampled with load)
//   pixel      RGBI colour out
//   de         display enable out
interface vdc_pixelshift_if;
    logic       enable;
    logic       frame;
    logic       load;
    logic       disp;
    logic [7:0] char_in;
    logic [7:0] attr_in;
    logic [4:0] line;
    logic       cursor_hit;
    logic [3:0] pixel;
    logic       de;

    modport master (
        output enable, frame, load, disp, char_in, attr_in, line, cursor_hit,
        input  pixel, de
    );

    modport slave (
        input  enable, frame, load, disp, char_in, attr_in, line, cursor_hit,
        output pixel, de
    );
endinterface

// File: rtl/vdc_pixelshift.sv
// rtl/vdc_pixelshift.sv - VDC pixel serializer: char/attr bytes to one RGBI colour per pixel enable
//
// Optional feature macro: VDC_CURSOR_EN (hardware cursor inversion). When undefined the
// cursor inputs are accepted but ignored.
//
// Ports:
//   clk, reset_n   core clock, asynchronous active-low reset
//   pif            vdc_pixelshift_if.slave: enable/frame/load/disp/char_in/attr_in/line/
//                  cursor_hit in, pixel/de out (registered)
//   reg_cth        cell width - 1
//   reg_cdh        displayed pixels - 1 (clamped to reg_cth)
//   reg_text       1 = bitmap mode, 0 = text mode
//   reg_atr        attribute enable
//   reg_semi       semigraphic gap extension
//   reg_rvs        global reverse
//   reg_dbl        double pixel width
//   reg_ul         underline scanline
//   reg_fg         foreground when attributes are off
//   reg_bg         background colour
//   reg_cm         cursor mode (00 solid, 01 off, 10 blink slow-ish, 11 blink slow)
//   reg_cs, reg_ce cursor start line, cursor end line (exclusive)
module vdc_pixelshift #(
    parameter int BLINK_BITS = 5
) (
    input  logic                 clk,
    input  logic                 reset_n,
    vdc_pixelshift_if.slave      pif,
    input  logic [3:0]           reg_cth,
    input  logic [3:0]           reg_cdh,
    input  logic                 reg_text,
    input  logic                 reg_atr,
    input  logic                 reg_semi,
    input  logic                 reg_rvs,
    input  logic                 reg_dbl,
    input  logic [4:0]           reg_ul,
    input  logic [3:0]           reg_fg,
    input  logic [3:0]           reg_bg,
    input  logic [1:0]           reg_cm,
    input  logic [4:0]           reg_cs,
    input  logic [4:0]           reg_ce
);

    logic [7:0]            r_shift;
    logic [3:0]            r_px;
    logic                  r_tog;
    logic                  r_last;     // bit most recently shifted out, reused in the gap
    logic [BLINK_BITS-1:0] r_cnt;
    logic [3:0]            r_fg;
    logic                  r_rev;
    logic                  r_ul;
    logic                  r_blk;
    logic                  r_disp;
    logic [3:0]            r_pixel;
    logic                  r_de;

    logic [3:0]            w_cdh;
    logic                  w_in_disp;
    logic                  w_cur_act;
    logic                  w_b;

    // Displayed width can never exceed the cell width.
    assign w_cdh     = (reg_cdh > reg_cth) ? reg_cth : reg_cdh;
    assign w_in_disp = (r_px <= w_cdh);

`ifdef VDC_CURSOR_EN
    logic r_cur;
    logic w_cur_mode;

    always_comb begin
        w_cur_mode = 1'b0;
        case (reg_cm)
            2'b00: w_cur_mode = 1'b1;
            2'b01: w_cur_mode = 1'b0;
            2'b10: w_cur_mode = r_cnt[3];
            2'b11: w_cur_mode = r_cnt[4];
            default: w_cur_mode = 1'b0;
        endcase
    end

    assign w_cur_act = r_cur && (pif.line >= reg_cs) && (pif.line < reg_ce) && w_cur_mode;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_cur <= 1'b0;
        end else if (pif.enable && pif.load) begin
            r_cur <= pif.cursor_hit;
        end
    end

    logic w_unused;
    assign w_unused = pif.attr_in[7];
`else
    assign w_cur_act = 1'b0;

    logic w_unused;
    assign w_unused = ^{pif.attr_in[7], pif.cursor_hit, reg_cm, reg_cs, reg_ce};
`endif

    // Pixel bit: data bit, gap handling, text-mode decorations, reverse, then cursor.
    always_comb begin
        w_b = 1'b0;
        if (w_in_disp) begin
            w_b = r_shift[7];
        end else begin
            w_b = reg_semi & r_last;
        end
        if (!reg_text) begin
            if (r_ul && (pif.line == reg_ul)) begin
                w_b = 1'b1;
            end
            if (r_blk && r_cnt[BLINK_BITS-1]) begin
                w_b = 1'b0;
            end
        end
        w_b = w_b ^ r_rev ^ reg_rvs ^ w_cur_act;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_shift <= '0;
            r_px    <= '0;
            r_tog   <= 1'b0;
            r_last  <= 1'b0;
            r_cnt   <= '0;
            r_fg    <= '0;
            r_rev   <= 1'b0;
            r_ul    <= 1'b0;
            r_blk   <= 1'b0;
            r_disp  <= 1'b0;
            r_pixel <= '0;
            r_de    <= 1'b0;
        end else if (pif.enable) begin
            if (pif.frame) begin
                r_cnt <= r_cnt + 1'b1;
            end

            // Output always reflects the state before this enable, so the pixel of the
            // outgoing cell is still emitted on the enable that loads the next cell.
            r_pixel <= (r_disp && w_b) ? r_fg : reg_bg;
            r_de    <= r_disp;

            if (pif.load) begin
                r_shift <= pif.char_in;
                r_px    <= '0;
                r_tog   <= 1'b0;
                r_last  <= 1'b0;
                r_disp  <= pif.disp;
                if (reg_atr) begin
                    r_fg  <= pif.attr_in[3:0];
                    r_rev <= pif.attr_in[6];
                    r_ul  <= pif.attr_in[5];
                    r_blk <= pif.attr_in[4];
                end else begin
                    r_fg  <= reg_fg;
                    r_rev <= 1'b0;
                    r_ul  <= 1'b0;
                    r_blk <= 1'b0;
                end
            end else if (reg_dbl && !r_tog) begin
                r_tog <= 1'b1;
            end else begin
                r_tog <= 1'b0;
                // Saturate rather than wrap when the next load arrives late.
                if (r_px < reg_cth) begin
                    r_px <= r_px + 1'b1;
                end
                if (w_in_disp) begin
                    r_shift <= {r_shift[6:0], 1'b0};
                    r_last  <= r_shift[7];
                end
            end
        end
    end

    assign pif.pixel = r_pixel;
    assign pif.de    = r_de;

endmodule
